// File: rtl/bfly_pkg.sv
// bfly_pkg: shared widths, sample type and helpers for the butterfly datapath
package bfly_pkg;

    localparam int BFLY_DW = 15;
    localparam int BFLY_N  = 8;

    typedef logic signed [BFLY_DW-1:0] sample_t;

    // ceil(log2(v)); returns 0 for v <= 1
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // address width that never collapses to zero bits
    function automatic int addr_w(input int v);
        return (clog2(v) < 1) ? 1 : clog2(v);
    endfunction

endpackage

// File: rtl/bfly_pp_bank.sv
// bfly_pp_bank: N x DW register bank, one write port, two combinational read ports
module bfly_pp_bank
    import bfly_pkg::*;
#(
    parameter int DW = BFLY_DW,
    parameter int N  = BFLY_N,
    parameter int AW = addr_w(N)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr_a,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] rdata_a,
    output logic [DW-1:0] rdata_b
);

    logic [DW-1:0] mem [N];

    // sample storage; contents are deliberately left unreset
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/bfly_pair_feeder.sv
// bfly_pair_feeder: ping-pong block buffer emitting mirrored operand pairs for the butterfly
module bfly_pair_feeder
    import bfly_pkg::*;
#(
    parameter int DW = BFLY_DW,
    parameter int N  = BFLY_N,
    parameter int IW = addr_w(N / 2)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_a,
    output logic [DW-1:0] out_b,
    output logic [IW-1:0] out_idx,
    output logic          out_last
);

    localparam int AW = addr_w(N);
    localparam logic [AW-1:0] W_LAST = AW'(N - 1);
    localparam logic [IW-1:0] R_LAST = IW'(N / 2 - 1);

    logic [1:0]    full;
    logic          wsel, rsel;
    logic [AW-1:0] wcnt;
    logic [IW-1:0] rcnt;
    logic          accept, consume, wdone, rdone;
    logic [1:0]    set_full, clr_full;
    logic [AW-1:0] raddr_a, raddr_b;
    logic [DW-1:0] a0, b0, a1, b1;

    // handshake decode uses registered flags only, so in_ready never sees out_ready
    assign in_ready  = !full[wsel];
    assign out_valid = full[rsel];
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;
    assign wdone     = accept && (wcnt == W_LAST);
    assign rdone     = consume && (rcnt == R_LAST);
    assign set_full  = wdone ? (wsel ? 2'b10 : 2'b01) : 2'b00;
    assign clr_full  = rdone ? (rsel ? 2'b10 : 2'b01) : 2'b00;

    // both banks see the same mirrored read addresses; rsel picks the live one
    assign raddr_a = AW'(rcnt);
    assign raddr_b = W_LAST - AW'(rcnt);

    bfly_pp_bank #(.DW(DW), .N(N), .AW(AW)) u_bank0 (
        .clk     (clk),
        .we      (accept && !wsel),
        .waddr   (wcnt),
        .wdata   (in_data),
        .raddr_a (raddr_a),
        .raddr_b (raddr_b),
        .rdata_a (a0),
        .rdata_b (b0)
    );

    bfly_pp_bank #(.DW(DW), .N(N), .AW(AW)) u_bank1 (
        .clk     (clk),
        .we      (accept && wsel),
        .waddr   (wcnt),
        .wdata   (in_data),
        .raddr_a (raddr_a),
        .raddr_b (raddr_b),
        .rdata_a (a1),
        .rdata_b (b1)
    );

    // outputs are zeroed whenever no pair is presented
    always_comb begin
        out_a    = out_valid ? (rsel ? a1 : a0) : '0;
        out_b    = out_valid ? (rsel ? b1 : b0) : '0;
        out_idx  = out_valid ? rcnt : '0;
        out_last = out_valid && (rcnt == R_LAST);
    end

    // flags and counters; writer and reader never touch the same bank's flag in one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= '0;
            wsel <= 1'b0;
            rsel <= 1'b0;
            wcnt <= '0;
            rcnt <= '0;
        end else begin
            full <= (full | set_full) & ~clr_full;
            if (accept) begin
                wcnt <= wdone ? '0 : wcnt + 1'b1;
                wsel <= wsel ^ wdone;
            end
            if (consume) begin
                rcnt <= rdone ? '0 : rcnt + 1'b1;
                rsel <= rsel ^ rdone;
            end
        end
    end

endmodule

// File: tb/tb_bfly_pair_feeder.sv
// tb_bfly_pair_feeder: table vectors, directed corner sequences and a pair scoreboard
module tb_bfly_pair_feeder;

    localparam int DW = 15;
    localparam int N  = 8;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_a;
    logic [DW-1:0] out_b;
    logic [IW-1:0] out_idx;
    logic          out_last;

    bfly_pair_feeder #(.DW(DW), .N(N), .IW(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          iv;
        logic [DW-1:0] d;
        logic          ordy;
        logic          ir;
        logic          ov;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [IW-1:0] idx;
        logic          last;
    } vec_t;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [IW-1:0] idx;
        logic          last;
    } pair_t;

    vec_t          tv[13];
    pair_t         sb[$];
    logic [DW-1:0] blk[$];
    int            tests = 0;
    int            fails = 0;
    int            acc_cnt = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // checks presented pairs against the queue and builds expected pairs from accepted samples
    task automatic monitor();
        pair_t p;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("out_valid", out_valid, sb.size() > 0);
                if (out_valid && sb.size() > 0) begin
                    chk("pair", {out_a, out_b, out_idx, out_last},
                        {sb[0].a, sb[0].b, sb[0].idx, sb[0].last});
                    if (out_ready) sb.delete(0);
                end else if (!out_valid) begin
                    chk("idle_zero", {out_a, out_b, out_idx, out_last}, '0);
                end
                if (in_valid && in_ready) begin
                    blk.push_back(in_data);
                    acc_cnt++;
                    if (blk.size() == N) begin
                        for (int k = 0; k < N / 2; k++) begin
                            p.a    = blk[k];
                            p.b    = blk[N-1-k];
                            p.idx  = IW'(k);
                            p.last = (k == N / 2 - 1);
                            sb.push_back(p);
                        end
                        blk.delete();
                    end
                end
            end
        end
    endtask

    task automatic step(input logic iv, input logic [DW-1:0] d, input logic ordy);
        @(posedge clk);
        #1;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
    endtask

    task automatic drain();
        int n;
        n = 0;
        step(1'b0, '0, 1'b1);
        while (!(sb.size() == 0 && !out_valid) && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("drain_in_time", n < 200, 1);
    endtask

    task automatic reset_now();
        rst_n = 1'b0;
        #1;
        chk("async_reset", {in_ready, out_valid, out_a, out_b, out_idx, out_last}, {1'b1, 34'd0});
        sb.delete();
        blk.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [DW-1:0] sv4[8];
        logic [33:0]   held, cur;
        logic          stalled;
        int            base;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++)
            tv[i] = '{1'b1, DW'(i + 1), 1'b1, 1'b1, 1'b0, '0, '0, '0, 1'b0};
        tv[8]  = '{1'b0, '0, 1'b1, 1'b1, 1'b1, 15'd1, 15'd8, 2'd0, 1'b0};
        tv[9]  = '{1'b0, '0, 1'b1, 1'b1, 1'b1, 15'd2, 15'd7, 2'd1, 1'b0};
        tv[10] = '{1'b0, '0, 1'b1, 1'b1, 1'b1, 15'd3, 15'd6, 2'd2, 1'b0};
        tv[11] = '{1'b0, '0, 1'b1, 1'b1, 1'b1, 15'd4, 15'd5, 2'd3, 1'b1};
        tv[12] = '{1'b0, '0, 1'b1, 1'b1, 1'b0, '0, '0, '0, 1'b0};
        sv4 = '{15'h4000, 15'h3fff, 15'h7fff, 15'd0, 15'd1, 15'h7ffe, 15'd12345, 15'd20423};
        fork
            monitor();
        join_none
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_state", {in_ready, out_valid, out_a, out_b, out_idx, out_last}, {1'b1, 34'd0});

        // first block, cycle-exact against the table
        for (int i = 0; i < 13; i++) begin
            step(tv[i].iv, tv[i].d, tv[i].ordy);
            @(negedge clk);
            chk($sformatf("t1_vec%0d", i), {in_ready, out_valid, out_a, out_b, out_idx, out_last},
                {tv[i].ir, tv[i].ov, tv[i].a, tv[i].b, tv[i].idx, tv[i].last});
        end

        // back-to-back stream of three blocks
        for (int i = 1; i <= 24; i++) begin
            step(1'b1, DW'(i), 1'b1);
            @(negedge clk);
            chk("t2_in_ready", in_ready, 1);
        end
        drain();

        // both banks full, input held off until the older bank is fully read
        base = acc_cnt;
        for (int i = 0; i < 16; i++) step(1'b1, DW'(100 + i), 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 15'd999, 1'b0);
            @(negedge clk);
            chk("t3_held", {in_ready, 32'(acc_cnt - base)}, {1'b0, 32'd16});
        end
        step(1'b0, '0, 1'b1);
        @(negedge clk);
        chk("t3_p0", {out_valid, out_idx}, {1'b1, 2'd0});
        step(1'b0, '0, 1'b0);
        @(negedge clk);
        chk("t3_one_pair", {in_ready, out_idx}, {1'b0, 2'd1});
        step(1'b0, '0, 1'b1);
        @(negedge clk);
        chk("t3_p1", in_ready, 0);
        step(1'b0, '0, 1'b1);
        @(negedge clk);
        chk("t3_p2", in_ready, 0);
        step(1'b0, '0, 1'b1);
        @(negedge clk);
        chk("t3_p3", {in_ready, out_idx, out_last}, {1'b0, 2'd3, 1'b1});
        step(1'b0, '0, 1'b1);
        @(negedge clk);
        chk("t3_reopen", in_ready, 1);
        drain();

        // signed extremes with stalls; outputs must hold while stalled
        for (int i = 0; i < 8; i++) step(1'b1, sv4[i], 1'b1);
        stalled = 1'b0;
        held = '0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, '0, (i % 2) == 0);
            @(negedge clk);
            cur = {out_valid, out_a, out_b, out_idx, out_last};
            if (i == 0) chk("t4_first", {out_a, out_b}, {15'h4000, 15'd20423});
            if (stalled) chk("t4_stable", cur, held);
            stalled = out_valid && !out_ready;
            held = cur;
        end
        drain();

        // reset with a half-read full bank plus a partial block
        for (int i = 0; i < 8; i++) step(1'b1, DW'(200 + i), 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, DW'(300 + i), 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        @(negedge clk);
        chk("t5_pre_reset", {out_valid, out_idx}, {1'b1, 2'd2});
        #2;
        reset_now();
        for (int i = 0; i < 8; i++) step(1'b1, DW'(400 + i), 1'b1);
        drain();

        // reset after only a partial block
        for (int i = 0; i < 5; i++) step(1'b1, DW'(500 + i), 1'b1);
        @(negedge clk);
        #2;
        reset_now();
        for (int i = 0; i < 8; i++) step(1'b1, DW'(600 + i), 1'b1);
        drain();

        // sparse input, one sample every third cycle
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, DW'(i), 1'b1);
            step(1'b0, '0, 1'b1);
            step(1'b0, '0, 1'b1);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
